// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and framing constants for the boot loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        RUN,
        ERROR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream input and instruction memory write port of the loader
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    // master drives the byte stream and observes the memory writes; slave is the loader
    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs big-endian bytes into 32-bit instruction words
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shreg;
    logic [1:0]  cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (byte_valid) begin
            shreg <= {shreg[15:0], byte_data};
            cnt   <= cnt + 2'd1;
        end
    end

    // the 4th byte completes the word combinationally so the top can register it in one step
    assign word_valid = byte_valid && (cnt == 2'(WORD_BYTES - 1));
    assign word       = {shreg, byte_data};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: writes a checksummed word image into imem, then releases the core
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MAX_WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          err
);

    state_t      state, state_next;
    logic [15:0] count, index, hdr_count;
    logic [7:0]  xor_acc;
    logic        accept, word_valid;
    logic [31:0] word;

    assign bus.in_ready = (state == HDR_HI) || (state == HDR_LO) ||
                          (state == DATA)   || (state == CSUM);
    assign accept    = bus.in_valid && bus.in_ready;
    assign hdr_count = {count[15:8], bus.in_data};

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (state != DATA),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_next = state;
        case (state)
            HDR_HI: if (accept) state_next = HDR_LO;
            HDR_LO: if (accept) begin
                if (hdr_count > 16'(MAX_WORDS)) state_next = ERROR;
                else if (hdr_count == 16'd0)    state_next = CSUM;
                else                            state_next = DATA;
            end
            DATA:   if (word_valid && (index == count - 16'd1)) state_next = CSUM;
            CSUM:   if (accept) state_next = (bus.in_data == xor_acc) ? RUN : ERROR;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= HDR_HI;
            count          <= '0;
            index          <= '0;
            xor_acc        <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state       <= state_next;
            bus.imem_we <= 1'b0;
            if (accept && (state != CSUM)) xor_acc <= xor_acc ^ bus.in_data;
            if (accept && (state == HDR_HI)) count <= {bus.in_data, 8'h00};
            if (accept && (state == HDR_LO)) count <= hdr_count;
            if (word_valid) begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= BASE_ADDR + {14'd0, index, 2'b00};
                bus.imem_wdata <= word;
                index          <= index + 16'd1;
            end
            // status follows the next state so it changes together with the FSM
            cpu_reset <= (state_next != RUN);
            done      <= (state_next == RUN);
            err       <= (state_next == ERROR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed vector bench for imem_loader
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_reset, done, err;

    imem_loader_if bus();

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wa.push_back(bus.imem_addr);
            wd.push_back(bus.imem_wdata);
        end
    end

    typedef struct {
        int          nbytes;
        logic [87:0] stream;
        int          gap_max;
        int          exp_writes;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] exp_addr[2];
    logic [31:0] exp_data[2];
    logic [87:0] clean;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        wa.delete();
        wd.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int n;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) check("ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [87:0] s, input int nbytes, input int gap_max);
        for (int i = 0; i < nbytes; i++) begin
            if (i == nbytes - 1) begin
                check("pre_final_done", 32'(done), 32'd0);
                check("pre_final_err", 32'(err), 32'd0);
            end
            send_byte(s[87 - 8*i -: 8], gap_max);
        end
    endtask

    task automatic check_writes(input int n, input string tag);
        check({tag, "_nwrites"}, 32'(wa.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (wa.size() > k) begin
                check({tag, "_addr"}, wa[k], exp_addr[k]);
                check({tag, "_data"}, wd[k], exp_data[k]);
            end else begin
                check({tag, "_write_missing"}, 32'(wa.size()), 32'(k + 1));
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        clean = 88'h0002_2002_0005_2003_000C_0A;
        exp_addr[0] = 32'h0000_0000; exp_data[0] = 32'h2002_0005;
        exp_addr[1] = 32'h0000_0004; exp_data[1] = 32'h2003_000C;

        vecs[0] = '{11, clean, 0, 2, 1'b1, 1'b0};
        vecs[1] = '{11, 88'h0002_2002_0005_2003_000C_0B, 0, 2, 1'b0, 1'b1};
        vecs[2] = '{3, {24'h000000, 64'h0}, 0, 0, 1'b1, 1'b0};
        vecs[3] = '{2, {16'h0041, 72'h0}, 0, 0, 1'b0, 1'b1};
        vecs[4] = '{11, clean, 5, 2, 1'b1, 1'b0};

        do_reset();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'd0);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            send_stream(vecs[i].stream, vecs[i].nbytes, vecs[i].gap_max);
            check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_cpu_reset", i), 32'(cpu_reset), 32'(!vecs[i].exp_done));
            check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
            check_writes(vecs[i].exp_writes, $sformatf("v%0d", i));
            // bytes offered after a terminal state must be ignored
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hA5;
            repeat (4) begin @(posedge clk); #1; end
            bus.in_valid = 1'b0;
            check($sformatf("v%0d_late_nwrites", i), 32'(wa.size()), 32'(vecs[i].exp_writes));
            check($sformatf("v%0d_late_done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_late_err", i), 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].exp_writes == 2) begin
                check($sformatf("v%0d_hold_addr", i), bus.imem_addr, 32'h0000_0004);
                check($sformatf("v%0d_hold_wdata", i), bus.imem_wdata, 32'h2003_000C);
            end
        end

        do_reset();
        send_stream(clean, 7, 0);
        check("mid_first_word", 32'(wa.size()), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_cpu_reset", 32'(cpu_reset), 32'd1);
        check("mid_async_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_async_we", 32'(bus.imem_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wa.delete();
        wd.delete();
        repeat (3) begin @(posedge clk); #1; end
        check("mid_no_partial_write", 32'(wa.size()), 32'd0);
        send_stream(clean, 11, 0);
        check_writes(2, "mid_resend");
        check("mid_resend_done", 32'(done), 32'd1);
        check("mid_resend_cpu_reset", 32'(cpu_reset), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle MIPS core. It receives a byte stream containing a word count, the instruction words and an XOR checksum. It writes each word into the instruction memory's write port and holds the core in reset. The core is released only after the image loads cleanly. It is the writer-side counterpart to the core's instruction fetch: it fills the memory the core later reads, starting at the reset PC.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; matches the core's reset PC.
- MAX_WORDS, 64: largest accepted word count; equals instruction memory depth.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high; clears all state.
- in_valid, in, 1: a byte is offered on in_data.
- in_data, in, 8: stream byte.
- in_ready, out, 1: loader accepts a byte this cycle; a byte is accepted when in_valid && in_ready.
- imem_we, out, 1: one-cycle write strobe to instruction memory.
- imem_addr, out, 32: byte address of the write; word-aligned.
- imem_wdata, out, 32: instruction word.
- cpu_reset, out, 1: reset to the core; high until the load succeeds.
- done, out, 1: load completed; the core is running.
- err, out, 1: load failed; the core stays in reset.

## Operation
- Stream format, in order:
  - count: 2 bytes, big-endian.
  - count words: 4 bytes each, big-endian.
  - 1 checksum byte, equal to the XOR of every preceding byte, header included.
- States: HDR_HI, HDR_LO, DATA, CSUM, RUN, ERROR.
- HDR_HI: accept the count MSB, then go to HDR_LO.
- HDR_LO: accept the count LSB, then:
  - count > MAX_WORDS: go to ERROR.
  - count == 0: go to CSUM.
  - otherwise: go to DATA.
- DATA: assemble 4 bytes, first byte into bits [31:24].
  - On the 4th byte, write the word at BASE_ADDR + 4*index, then increment index.
  - After the word with index == count-1, go to CSUM.
- CSUM: compare the received byte with the running XOR.
  - Match: go to RUN.
  - Mismatch: go to ERROR.
- RUN and ERROR are terminal; only reset leaves them.
- in_ready = 1 in HDR_HI, HDR_LO, DATA and CSUM; 0 in RUN and ERROR. No byte is ever dropped or double-counted.
- Index and count are 16-bit unsigned. The address is computed as 32-bit BASE_ADDR + {index,2'b00}, and the computation is exact for any count ≤ MAX_WORDS.
- Gaps in in_valid stall the FSM with no state change. There is no timeout.

## Timing
- Values after reset:
  - state = HDR_HI.
  - in_ready = 1, cpu_reset = 1.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - done = 0, err = 0.
  - Running XOR, index and count all 0.
- Write latency: imem_we, imem_addr and imem_wdata are registered.
  - The strobe is high for exactly the cycle after the 4th byte of a word is accepted.
  - imem_addr and imem_wdata hold their values until the next write.
- Back-to-back words with no in_valid gaps produce at most one write strobe per 4 cycles.
- Checksum accepted with a match: on the next cycle cpu_reset falls to 0 and done rises to 1, in the same cycle.
- Checksum mismatch, or oversize count: err rises the cycle after the offending byte. in_ready falls in the same cycle. cpu_reset stays 1.
- Reset asserted mid-load:
  - Takes effect immediately, asynchronously.
  - Any partial word is discarded and no write strobe occurs.
  - cpu_reset returns to 1 and the next accepted byte is treated as HDR_HI.

## Structure
- Shared package imem_loader_pkg holds:
  - The state enum.
  - HDR_BYTES = 2 and WORD_BYTES = 4.
  - The default BASE_ADDR.
- One sub-module, word_assembler:
  - Shifts in bytes and asserts word_valid on the 4th byte.
  - Has a clear input driven on reset and on leaving DATA.
- The FSM, XOR accumulator, index/count registers and output registers live in imem_loader.

## Test plan
- Clean 2-word load, no gaps.
  - Stimulus: 00 02 20 02 00 05 20 03 00 0C 0A.
  - Required: a write of 0x20020005 at addr 0x0, then 0x2003000C at addr 0x4, each a one-cycle strobe.
  - Required: cpu_reset falls and done rises the cycle after 0A.
- Same stream with checksum 0B.
  - Required: both writes occur, then err = 1, cpu_reset stays 1 and in_ready = 0.
  - Required: later bytes are ignored.
- Empty image: 00 00 00.
  - Required: no imem_we, and done = 1 the cycle after the third byte.
- Oversize count with MAX_WORDS = 64: 00 41.
  - Required: err = 1 the cycle after 41, no writes, in_ready = 0.
- Clean 2-word stream with random 0–5 cycle gaps in in_valid.
  - Required: the same writes and addresses as the first test, and exactly two strobes.
- Reset pulse after byte 7 of the first stream, then the full stream resent.
  - Required: the partial word is never written.
  - Required: the final memory contents and done match the first test.
